// File: rtl/agc_timing_pkg.sv
// Shared timing definitions for the AGC timepulse generator and the downstream
// timing-gate wrappers.
package agc_timing_pkg;

  localparam int TP_COUNT = 12;
  localparam int T01_IDX  = 0;
  localparam int T12_IDX  = 11;
  localparam int MCT_CW   = 16;
  // Wide enough for any DIV in 1..16.
  localparam int PRE_CW   = 4;

  localparam logic [TP_COUNT-1:0] T01_MASK = 12'h001;

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2,
    ST_STEP = 2'd3
  } agc_state_e;

  function automatic logic is_active(input agc_state_e s);
    return (s == ST_RUN) || (s == ST_STEP);
  endfunction

endpackage

// File: rtl/tp_prescaler.sv
// Divides clk into timepulse slots of DIV clocks and flags the last clock of each
// slot. The count is held at zero whenever the timing chain is idle.
module tp_prescaler
  import agc_timing_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run_next,
  output logic ph_last
);

  localparam logic [PRE_CW-1:0] LAST = PRE_CW'(DIV - 1);

  logic [PRE_CW-1:0] cnt_q;
  logic [PRE_CW-1:0] cnt_n;

  always_comb begin
    cnt_n = '0;
    if (!clr && (cnt_q != LAST)) cnt_n = cnt_q + 1'b1;
  end

  // ph_last is registered from the next count so it lines up with cnt_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      ph_last <= 1'b0;
    end else begin
      cnt_q   <= cnt_n;
      ph_last <= run_next && (cnt_n == LAST);
    end
  end

endmodule

// File: rtl/agc_timepulse_gen.sv
// AGC timepulse generator: twelve one-hot timepulses per memory cycle time with a
// stop/single-step handshake that only takes effect at MCT boundaries.
module agc_timepulse_gen
  import agc_timing_pkg::*;
#(
  parameter int DIV           = 2,
  parameter bit START_STOPPED = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stop_req,
  input  logic                step_req,
  output logic [TP_COUNT-1:0] tp,
  output logic                mct_start,
  output logic                ph_last,
  output logic                halted,
  output logic [MCT_CW-1:0]   mct_count,
  output agc_state_e          state_dbg
);

  // Handshake: stop_req is a level sampled only at the end of an MCT (halt) and
  // while halted (resume when low); step_req is a pulse honoured only while halted
  // with stop_req high, running exactly one MCT. Neither ever truncates an MCT.

  agc_state_e          state_q, state_n;
  logic [TP_COUNT-1:0] tp_n;
  logic                mct_start_n;
  logic                halted_n;
  logic [MCT_CW-1:0]   count_n;

  tp_prescaler #(.DIV(DIV)) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .clr      (!is_active(state_q)),
    .run_next (is_active(state_n)),
    .ph_last  (ph_last)
  );

  always_comb begin
    state_n     = state_q;
    tp_n        = tp;
    mct_start_n = 1'b0;
    halted_n    = halted;
    count_n     = mct_count;
    case (state_q)
      ST_RST: begin
        if (START_STOPPED) begin
          state_n  = ST_HALT;
          tp_n     = '0;
          halted_n = 1'b1;
        end else begin
          state_n     = ST_RUN;
          tp_n        = T01_MASK;
          mct_start_n = 1'b1;
          halted_n    = 1'b0;
        end
      end
      ST_RUN, ST_STEP: begin
        if (ph_last) begin
          if (tp[T12_IDX]) begin
            count_n = mct_count + 1'b1;
            if (stop_req) begin
              state_n  = ST_HALT;
              tp_n     = '0;
              halted_n = 1'b1;
            end else begin
              state_n     = ST_RUN;
              tp_n        = T01_MASK;
              mct_start_n = 1'b1;
            end
          end else begin
            tp_n = tp << 1;
          end
        end
      end
      ST_HALT: begin
        tp_n     = '0;
        halted_n = 1'b1;
        // Dropping stop_req wins over a simultaneous step request.
        if (!stop_req) begin
          state_n     = ST_RUN;
          tp_n        = T01_MASK;
          mct_start_n = 1'b1;
          halted_n    = 1'b0;
        end else if (step_req) begin
          state_n     = ST_STEP;
          tp_n        = T01_MASK;
          mct_start_n = 1'b1;
          halted_n    = 1'b0;
        end
      end
      default: begin
        state_n  = ST_RST;
        tp_n     = '0;
        halted_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RST;
      tp        <= '0;
      mct_start <= 1'b0;
      halted    <= 1'b0;
      mct_count <= '0;
    end else begin
      state_q   <= state_n;
      tp        <= tp_n;
      mct_start <= mct_start_n;
      halted    <= halted_n;
      mct_count <= count_n;
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_agc_timepulse_gen.sv
// Bench for agc_timepulse_gen: a DIV=2 free-running build and a DIV=1 start-stopped
// build driven side by side and scored against a slot-position reference model.
module tb_agc_timepulse_gen;
  import agc_timing_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stop_a, step_a, stop_b, step_b;
  logic [11:0] tp_a, tp_b;
  logic        mct_start_a, ph_last_a, halted_a;
  logic        mct_start_b, ph_last_b, halted_b;
  logic [15:0] mct_count_a, mct_count_b;
  agc_state_e  state_a, state_b;

  agc_timepulse_gen #(.DIV(2), .START_STOPPED(1'b0)) u_a (
    .clk(clk), .rst(rst), .stop_req(stop_a), .step_req(step_a),
    .tp(tp_a), .mct_start(mct_start_a), .ph_last(ph_last_a), .halted(halted_a),
    .mct_count(mct_count_a), .state_dbg(state_a)
  );

  agc_timepulse_gen #(.DIV(1), .START_STOPPED(1'b1)) u_b (
    .clk(clk), .rst(rst), .stop_req(stop_b), .step_req(step_b),
    .tp(tp_b), .mct_start(mct_start_b), .ph_last(ph_last_b), .halted(halted_b),
    .mct_count(mct_count_b), .state_dbg(state_b)
  );

  // Reference model: mode plus clock position within the current MCT.
  localparam int M_RST = 0, M_RUN = 1, M_HALT = 2, M_STEP = 3;
  int          div_c [2] = '{2, 1};
  bit          ss_c  [2] = '{1'b0, 1'b1};
  int          m_mode[2];
  int          m_pos [2];
  logic [15:0] m_cnt [2];

  logic [61:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  function automatic logic [30:0] model_out(input int i);
    logic [11:0] tpv;
    logic        run;
    tpv = '0;
    run = (m_mode[i] == M_RUN) || (m_mode[i] == M_STEP);
    if (run) tpv[m_pos[i] / div_c[i]] = 1'b1;
    return {tpv, run && (m_pos[i] == 0), run && ((m_pos[i] % div_c[i]) == div_c[i] - 1),
            m_mode[i] == M_HALT, m_cnt[i]};
  endfunction

  task automatic model_step(input int i, input logic r, input logic stop, input logic step);
    if (r) begin
      m_mode[i] = M_RST;
      m_pos[i]  = 0;
      m_cnt[i]  = 16'h0000;
    end else begin
      case (m_mode[i])
        M_RST: begin
          m_mode[i] = ss_c[i] ? M_HALT : M_RUN;
          m_pos[i]  = 0;
        end
        M_RUN, M_STEP: begin
          if (m_pos[i] == 12 * div_c[i] - 1) begin
            m_cnt[i]  = m_cnt[i] + 16'd1;
            m_mode[i] = stop ? M_HALT : M_RUN;
            m_pos[i]  = 0;
          end else begin
            m_pos[i] = m_pos[i] + 1;
          end
        end
        default: begin
          if (!stop) begin
            m_mode[i] = M_RUN;
            m_pos[i]  = 0;
          end else if (step) begin
            m_mode[i] = M_STEP;
            m_pos[i]  = 0;
          end
        end
      endcase
    end
  endtask

  // One clock: model follows the edge, expectation queued, inputs free after negedge.
  task automatic tick();
    @(posedge clk);
    model_step(0, rst, stop_a, step_a);
    model_step(1, rst, stop_b, step_b);
    exp_q.push_back({model_out(0), model_out(1)});
    cyc++;
    @(negedge clk);
    #1;
  endtask

  task automatic wait_tp_a(input logic [11:0] mask, input int budget);
    int n;
    n = 0;
    while (tp_a !== mask && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (tp_a !== mask) begin
      failures++;
      $display("FAIL wait_tp_a got tp=%h exp tp=%h after %0d clks", tp_a, mask, n);
    end
  endtask

  task automatic preload_count_b(input logic [15:0] v);
    force u_b.mct_count = v;
    #1;
    release u_b.mct_count;
    m_cnt[1] = v;
  endtask

  // Monitor: every clock presents a full output word for each instance.
  always @(negedge clk) begin
    logic [61:0] e;
    logic [30:0] got_a, got_b;
    if (exp_q.size() != 0) begin
      e     = exp_q.pop_front();
      got_a = {tp_a, mct_start_a, ph_last_a, halted_a, mct_count_a};
      got_b = {tp_b, mct_start_b, ph_last_b, halted_b, mct_count_b};
      checks += 2;
      if (got_a !== e[61:31]) begin
        failures++;
        $display("FAIL out_a cyc=%0d got tp=%h ms=%b pl=%b h=%b cnt=%h exp tp=%h ms=%b pl=%b h=%b cnt=%h",
                 cyc, got_a[30:19], got_a[18], got_a[17], got_a[16], got_a[15:0],
                 e[61:50], e[49], e[48], e[47], e[46:31]);
      end
      if (got_b !== e[30:0]) begin
        failures++;
        $display("FAIL out_b cyc=%0d got tp=%h ms=%b pl=%b h=%b cnt=%h exp tp=%h ms=%b pl=%b h=%b cnt=%h",
                 cyc, got_b[30:19], got_b[18], got_b[17], got_b[16], got_b[15:0],
                 e[30:19], e[18], e[17], e[16], e[15:0]);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1; stop_a = 1'b0; step_a = 1'b0; stop_b = 1'b1; step_b = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (30) tick();

    // Stop requested mid-MCT: MCT completes, then a long halt.
    wait_tp_a(12'h010, 40);
    stop_a = 1'b1;
    repeat (80) tick();

    // Single step while halted.
    step_a = 1'b1; tick(); step_a = 1'b0;
    repeat (40) tick();

    // Resume and step together: resume wins, machine keeps running.
    stop_a = 1'b0; step_a = 1'b1; tick(); step_a = 1'b0;
    repeat (60) tick();

    // One-clock reset during T07.
    wait_tp_a(12'h040, 40);
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (30) tick();

    // DIV=1 build: release from halt and cross the counter wrap.
    stop_b = 1'b0;
    repeat (5) tick();
    preload_count_b(16'hFFFE);
    repeat (40) tick();

    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 39) == 0) stop_a = ~stop_a;
      if ($urandom_range(0, 29) == 0) stop_b = ~stop_b;
      step_a = ($urandom_range(0, 5) == 0);
      step_b = ($urandom_range(0, 5) == 0);
      rst    = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0; step_a = 1'b0; step_b = 1'b0;
    tick();

    n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending exp 0 pending", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
